// File: rtl/fsm_ctrl_pkg.sv
// Shared types and constants for the lab FSM sequencing controller.
package fsm_ctrl_pkg;

    localparam int STEP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE_ST  = 2'd0,
        RUN_ST   = 2'd1,
        BURST_ST = 2'd2,
        LOAD_ST  = 2'd3
    } ctrl_state_e;

    localparam logic [1:0] MODE_HALT   = 2'd0;
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_RUN    = 2'd2;
    localparam logic [1:0] MODE_BURST  = 2'd3;

    // Saturating increment for the display counter.
    function automatic logic [STEP_CNT_W-1:0] sat_inc(input logic [STEP_CNT_W-1:0] v);
        return (&v) ? v : v + STEP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // Synchronizer and debounce state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Accept a new level only after it has differed for DB_CYCLES straight cycles.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
                cnt_d   = '0;
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/fsm_step_ctrl.sv
// Step/reset sequencer for the lab Moore-machine cores: halt, single-step,
// free-run and counted-burst modes, plus FSM reload and a step counter.
module fsm_step_ctrl
    import fsm_ctrl_pkg::*;
#(
    parameter int CNT_W     = 24,
    parameter int DB_CYCLES = 16,
    parameter int BURST_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic                  step_btn,
    input  logic [CNT_W-1:0]      rate,
    input  logic [BURST_W-1:0]    burst_len,
    input  logic                  start,
    input  logic                  load_req,
    output logic                  step_en,
    output logic                  fsm_reset,
    output logic                  busy,
    output logic                  done,
    output logic [STEP_CNT_W-1:0] step_count
);

    ctrl_state_e           state_q, state_d;
    logic [CNT_W-1:0]      div_q, div_d;
    logic [CNT_W-1:0]      rate_q, rate_d;
    logic [BURST_W-1:0]    burst_q, burst_d;
    logic                  step_en_q, step_en_d;
    logic                  fsm_reset_q, fsm_reset_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [STEP_CNT_W-1:0] count_q, count_d;
    logic                  press;
    logic [CNT_W-1:0]      rate_eff;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (step_btn),
        .press_o(press)
    );

    // A zero period would never wrap; run it as period 1.
    assign rate_eff = (rate == '0) ? CNT_W'(1) : rate;

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE_ST;
            div_q       <= '0;
            rate_q      <= '0;
            burst_q     <= '0;
            step_en_q   <= 1'b0;
            fsm_reset_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            rate_q      <= rate_d;
            burst_q     <= burst_d;
            step_en_q   <= step_en_d;
            fsm_reset_q <= fsm_reset_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
        end
    end

    // Next state and next outputs; load_req overrides everything, then mode changes.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        rate_d      = rate_q;
        burst_d     = burst_q;
        step_en_d   = 1'b0;
        fsm_reset_d = 1'b0;
        done_d      = 1'b0;
        count_d     = count_q;

        if (load_req) begin
            state_d     = LOAD_ST;
            fsm_reset_d = 1'b1;
            burst_d     = '0;
            div_d       = '0;
            count_d     = '0;
        end else begin
            unique case (state_q)
                IDLE_ST: begin
                    unique case (mode)
                        MODE_SINGLE: step_en_d = press;
                        MODE_RUN: begin
                            state_d = RUN_ST;
                            div_d   = '0;
                            rate_d  = rate_eff;
                        end
                        MODE_BURST: begin
                            if (start) begin
                                burst_d = burst_len;
                                if (burst_len == '0) done_d = 1'b1;
                                else                 state_d = BURST_ST;
                            end
                        end
                        default: ;
                    endcase
                end
                RUN_ST: begin
                    if (mode != MODE_RUN) begin
                        state_d = IDLE_ST;
                    end else if (div_q == rate_q - CNT_W'(1)) begin
                        // Period is re-sampled only at the wrap.
                        div_d     = '0;
                        rate_d    = rate_eff;
                        step_en_d = 1'b1;
                    end else begin
                        div_d = div_q + CNT_W'(1);
                    end
                end
                BURST_ST: begin
                    if (mode != MODE_BURST) begin
                        state_d = IDLE_ST;
                        burst_d = '0;
                    end else if (burst_q != '0) begin
                        step_en_d = 1'b1;
                        burst_d   = burst_q - BURST_W'(1);
                    end else begin
                        // Last strobe is on the wire this cycle; done follows it.
                        done_d  = 1'b1;
                        state_d = IDLE_ST;
                    end
                end
                LOAD_ST: state_d = IDLE_ST;
                default: state_d = IDLE_ST;
            endcase
        end

        busy_d = (state_d != IDLE_ST);
        if (step_en_d) count_d = sat_inc(count_q);
    end

    assign step_en    = step_en_q;
    assign fsm_reset  = fsm_reset_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_fsm_step_ctrl.sv
// Scoreboard bench for fsm_step_ctrl: stimulus queues expected strobe events,
// a negedge monitor matches every step_en/done/fsm_reset against the queue.
module tb_fsm_step_ctrl;

    localparam int CNT_W = 24;
    localparam int DB    = 4;
    localparam int BW    = 8;
    localparam int EV_STEP = 0, EV_DONE = 1, EV_RST = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       mode = 2'd0;
    logic             step_btn = 1'b0;
    logic [CNT_W-1:0] rate = '0;
    logic [BW-1:0]    burst_len = '0;
    logic             start = 1'b0;
    logic             load_req = 1'b0;
    logic             step_en, fsm_reset, busy, done;
    logic [15:0]      step_count;

    typedef struct {
        int cyc;
        int kind;
        int cnt;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    bit  bulk = 1'b0;
    int  c;

    fsm_step_ctrl #(
        .CNT_W    (CNT_W),
        .DB_CYCLES(DB),
        .BURST_W  (BW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .step_btn  (step_btn),
        .rate      (rate),
        .burst_len (burst_len),
        .start     (start),
        .load_req  (load_req),
        .step_en   (step_en),
        .fsm_reset (fsm_reset),
        .busy      (busy),
        .done      (done),
        .step_count(step_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int cy, input int kind, input int cnt);
        ev_t e;
        e.cyc = cy; e.kind = kind; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic take(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_event @cycle %0d: got kind %0d, expected none", cyc, kind);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            chk("event_count", int'(step_count), e.cnt);
        end
    endtask

    // Monitor: flag overdue expectations, then match every visible strobe.
    initial forever begin
        @(negedge clk);
        if (!reset && !bulk) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_chk++; n_fail++;
                $display("FAIL missing_event: kind %0d expected at cycle %0d, absent by cycle %0d",
                         q[0].kind, q[0].cyc, cyc);
                q.delete(0);
            end
            if (step_en || fsm_reset) chk("step_rst_exclusive", int'(step_en && fsm_reset), 0);
            if (step_en)   take(EV_STEP);
            if (done)      take(EV_DONE);
            if (fsm_reset) take(EV_RST);
        end
    end

    initial begin
        // Reset state
        tick(3);
        chk("rst_step_en", int'(step_en), 0);
        chk("rst_fsm_reset", int'(fsm_reset), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(step_count), 0);
        reset = 1'b0;
        tick(2);

        // HALT: button activity must produce nothing
        step_btn = 1'b1; tick(10);
        step_btn = 1'b0; tick(12);
        chk("halt_busy", int'(busy), 0);
        chk("halt_count", int'(step_count), 0);

        // SINGLE: held press -> one step, 2 sync + DB debounce + 1 output stage
        mode = 2'd1; step_btn = 1'b1; c = cyc;
        expect_ev(c + DB + 3, EV_STEP, 1);
        tick(10);
        step_btn = 1'b0; tick(12);
        chk("single_count", int'(step_count), 1);
        // 2-cycle glitch is rejected
        step_btn = 1'b1; tick(2);
        step_btn = 1'b0; tick(12);
        chk("glitch_count", int'(step_count), 1);

        // RUN rate=5: strobes 5,10..30 cycles after entry
        mode = 2'd2; rate = 24'd5; c = cyc;
        for (int k = 1; k <= 6; k++) expect_ev(c + 1 + 5 * k, EV_STEP, 1 + k);
        tick(2);
        chk("run_busy", int'(busy), 1);
        tick(29);
        mode = 2'd0; tick(2);
        chk("run_exit_busy", int'(busy), 0);
        tick(8);
        chk("run_count", int'(step_count), 7);

        // RUN rate=0: every cycle, stops within one cycle of leaving
        rate = '0; mode = 2'd2; c = cyc;
        for (int k = 2; k <= 8; k++) expect_ev(c + k, EV_STEP, 6 + k);
        tick(8);
        mode = 2'd0; tick(5);
        chk("run0_count", int'(step_count), 14);

        // BURST of 3
        mode = 2'd3; burst_len = 8'd3; start = 1'b1; c = cyc;
        expect_ev(c + 2, EV_STEP, 15);
        expect_ev(c + 3, EV_STEP, 16);
        expect_ev(c + 4, EV_STEP, 17);
        expect_ev(c + 5, EV_DONE, 17);
        tick; start = 1'b0;
        tick(3);
        chk("burst_busy", int'(busy), 1);
        tick;
        chk("burst_end_busy", int'(busy), 0);
        tick(3);

        // BURST of 0: done only
        burst_len = 8'd0; start = 1'b1; c = cyc;
        expect_ev(c + 1, EV_DONE, 17);
        tick; start = 1'b0;
        chk("burst0_busy", int'(busy), 0);
        tick(3);

        // BURST of 10 cancelled by load_req after 4 strobes
        burst_len = 8'd10; start = 1'b1; c = cyc;
        for (int k = 0; k < 4; k++) expect_ev(c + 2 + k, EV_STEP, 18 + k);
        expect_ev(c + 6, EV_RST, 0);
        tick; start = 1'b0;
        tick(4);
        load_req = 1'b1;
        tick; load_req = 1'b0;
        chk("load_busy", int'(busy), 1);
        chk("load_count", int'(step_count), 0);
        tick;
        chk("load_idle_busy", int'(busy), 0);
        tick(15);
        chk("load_after_count", int'(step_count), 0);

        // Saturation: >65535 steps at rate 1
        bulk = 1'b1;
        rate = 24'd1; mode = 2'd2;
        tick(70000);
        chk("sat_count", int'(step_count), 16'hFFFF);
        mode = 2'd0; tick(3);
        bulk = 1'b0;
        load_req = 1'b1; c = cyc;
        expect_ev(c + 1, EV_RST, 0);
        tick; load_req = 1'b0;
        tick(3);
        chk("sat_clear_count", int'(step_count), 0);

        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
